// File: rtl/dly_sched_pkg.sv
// Shared types and helpers for the delayed-write responder (dly_sched_apply).
// Slot status struct, width helpers, and newest-maturing-slot selection.
package dly_sched_pkg;

   // Upper bounds for the flattened vectors that are handed to newest_idx().
   localparam int unsigned MAX_DEPTH = 16;
   localparam int unsigned MAX_DLY_W = 16;

   typedef logic [MAX_DLY_W-1:0] odly_t;

   // Per-slot status as seen by the top-level select logic.
   typedef struct packed {
      logic  valid;
      logic  mature;   // valid and countdown reached zero: retires this edge
      odly_t odly;     // original delay, zero-extended
   } slot_t;

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Among maturing slots, the one with the smallest original delay was
   // enqueued last (only one accept per cycle), so it carries the newest value.
   function automatic int unsigned newest_idx(
      input logic [MAX_DEPTH-1:0]                mature,
      input logic [MAX_DEPTH-1:0][MAX_DLY_W-1:0] odly
   );
      int unsigned best;
      logic        found;
      odly_t       best_d;
      best   = 0;
      found  = 1'b0;
      best_d = '1;
      for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
         if (mature[i] && (!found || (odly[i] < best_d))) begin
            best   = i;
            best_d = odly[i];
            found  = 1'b1;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/dly_sched_apply_if.sv
// Request channel of the delayed-write protocol: {delay, data} with valid/ready.
interface dly_sched_apply_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DLY_W  = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [DLY_W-1:0]  req_delay;
   logic [DATA_W-1:0] req_data;

   modport master (output req_valid, output req_delay, output req_data, input req_ready);
   modport slave  (input req_valid, input req_delay, input req_data, output req_ready);
endinterface

// File: rtl/dly_sched_slot.sv
// One scheduled-write slot: loads {delay, data}, counts down, flags maturity.
module dly_sched_slot
   import dly_sched_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DLY_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DLY_W-1:0]  load_dly,
   input  logic [DATA_W-1:0] load_data,
   output slot_t             stat,
   output logic [DATA_W-1:0] data
);

   logic             valid;
   logic [DLY_W-1:0] cnt;
   logic [DLY_W-1:0] odly;

   // Load on accept; otherwise retire at zero or count down (never wraps).
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         cnt   <= '0;
         odly  <= '0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         cnt   <= load_dly;
         odly  <= load_dly;
         data  <= load_data;
      end else if (valid) begin
         if (cnt == '0) valid <= 1'b0;
         else           cnt   <= cnt - 1'b1;
      end
   end

   // Status view for the top-level encoders.
   always_comb begin
      stat        = '0;
      stat.valid  = valid;
      stat.mature = valid && (cnt == '0);
      stat.odly   = MAX_DLY_W'(odly);
   end

endmodule

// File: rtl/dly_sched_apply.sv
// Delayed-write responder: applies each accepted {delay, data} to dly_q
// exactly delay+1 edges after acceptance; up to DEPTH writes outstanding.
// Optional DLY_SCHED_STATS_EN adds saturating accept/supersede counters.
module dly_sched_apply
   import dly_sched_pkg::*;
#(
   parameter int unsigned          DATA_W    = 32,
   parameter int unsigned          DLY_W     = 8,
   parameter int unsigned          DEPTH     = 4,   // 1..MAX_DEPTH
   parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   dly_sched_apply_if.slave            req,
   output logic [DATA_W-1:0]           dly_q,
   output logic                        applied,
   output logic [cnt_w(DEPTH)-1:0]     pending,
   output logic                        idle
`ifdef DLY_SCHED_STATS_EN
   ,
   output logic [31:0]                 stat_accepted,
   output logic [31:0]                 stat_superseded
`endif
);

   localparam int unsigned CNT_W = cnt_w(DEPTH);
   localparam int unsigned IDX_W = idx_w(DEPTH);

   slot_t                              stat [DEPTH];
   logic [DATA_W-1:0]                  slot_data [DEPTH];
   logic [DEPTH-1:0]                   load;
   logic                               ready;
   logic                               acc;
   logic [IDX_W-1:0]                   free_idx;
   logic [IDX_W-1:0]                   win_idx;
   logic                               any_mature;
   logic [CNT_W-1:0]                   ret_cnt;
   logic [MAX_DEPTH-1:0]               mature_vec;
   logic [MAX_DEPTH-1:0][MAX_DLY_W-1:0] odly_vec;

   assign acc           = req.req_valid && ready;
   assign req.req_ready = ready;
   assign idle          = (pending == '0);

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      assign load[g] = acc && (free_idx == IDX_W'(g));
      dly_sched_slot #(
         .DATA_W (DATA_W),
         .DLY_W  (DLY_W)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .load      (load[g]),
         .load_dly  (req.req_delay),
         .load_data (req.req_data),
         .stat      (stat[g]),
         .data      (slot_data[g])
      );
   end

   // Lowest-index free slot from registered state; retiring slots stay busy this cycle.
   always_comb begin
      ready    = 1'b0;
      free_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!stat[i].valid && !ready) begin
            ready    = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // Gather maturing slots, count retirements and pick the newest write.
   always_comb begin
      mature_vec = '0;
      odly_vec   = '0;
      ret_cnt    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mature_vec[i] = stat[i].mature;
         odly_vec[i]   = stat[i].odly;
         ret_cnt       = ret_cnt + CNT_W'(stat[i].mature);
      end
      any_mature = |mature_vec;
      win_idx    = IDX_W'(newest_idx(mature_vec, odly_vec));
   end

   // Output register and one-cycle applied pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         dly_q   <= RESET_VAL;
         applied <= 1'b0;
      end else begin
         applied <= any_mature;
         if (any_mature) dly_q <= slot_data[win_idx];
      end
   end

   // Outstanding-write counter: accept and retire may coincide.
   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= pending + CNT_W'(acc) - ret_cnt;
   end

`ifdef DLY_SCHED_STATS_EN
   logic [32:0] acc_sum;
   logic [32:0] sup_sum;

   always_comb begin
      acc_sum = {1'b0, stat_accepted} + 33'(acc);
      sup_sum = {1'b0, stat_superseded};
      if (any_mature) sup_sum = sup_sum + 33'(ret_cnt) - 33'd1;
   end

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_accepted   <= '0;
         stat_superseded <= '0;
      end else begin
         stat_accepted   <= acc_sum[32] ? '1 : acc_sum[31:0];
         stat_superseded <= sup_sum[32] ? '1 : sup_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_dly_sched_apply.sv
// Self-checking bench for dly_sched_apply: directed scenarios plus random
// traffic against an event-list model (due edge, data) kept in the bench.
module tb_dly_sched_apply;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DLY_W  = 8;
   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] RVAL   = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dly_q;
   logic        applied;
   logic [2:0]  pending;
   logic        idle;
`ifdef DLY_SCHED_STATS_EN
   logic [31:0] stat_accepted;
   logic [31:0] stat_superseded;
`endif

   dly_sched_apply_if #(.DATA_W(DATA_W), .DLY_W(DLY_W)) bus ();

   dly_sched_apply #(
      .DATA_W    (DATA_W),
      .DLY_W     (DLY_W),
      .DEPTH     (DEPTH),
      .RESET_VAL (RVAL)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (bus),
      .dly_q   (dly_q),
      .applied (applied),
      .pending (pending),
      .idle    (idle)
`ifdef DLY_SCHED_STATS_EN
      ,
      .stat_accepted   (stat_accepted),
      .stat_superseded (stat_superseded)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: list of scheduled writes in acceptance order.
   typedef struct {
      int          due;
      logic [31:0] data;
   } ev_t;

   ev_t         mq[$];
   int          edge_n = 0;
   logic [31:0] exp_q  = RVAL;
   logic        exp_app = 1'b0;
   int          m_acc = 0;
   int          m_sup = 0;
   int          total = 0;
   int          bad   = 0;
   int          last_acc_edge = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // One clock: drive at negedge, advance model at the edge, check at next negedge.
   task automatic step(input bit v, input logic [7:0] d, input logic [31:0] dat,
                       input bit r, output bit took);
      bit  rdy;
      int  n;
      ev_t keep[$];
      rst           = r;
      bus.req_valid = v;
      bus.req_delay = d;
      bus.req_data  = dat;
      rdy  = (mq.size() < DEPTH);
      took = 1'b0;
      if (!r) chk("ready", 64'(bus.req_ready), 64'(rdy));
      @(posedge clk);
      edge_n++;
      if (r) begin
         mq.delete();
         exp_q   = RVAL;
         exp_app = 1'b0;
         m_acc   = 0;
         m_sup   = 0;
      end else begin
         n = 0;
         foreach (mq[i]) begin
            if (mq[i].due == edge_n) begin
               n++;
               exp_q = mq[i].data;   // later entries were accepted later: last write wins
            end else begin
               keep.push_back(mq[i]);
            end
         end
         mq      = keep;
         exp_app = (n > 0);
         if (n > 0) m_sup += n - 1;
         if (v && rdy) begin
            mq.push_back('{due: edge_n + 1 + int'(d), data: dat});
            took          = 1'b1;
            last_acc_edge = edge_n;
            m_acc++;
         end
      end
      @(negedge clk);
      chk("dly_q",   64'(dly_q),   64'(exp_q));
      chk("applied", 64'(applied), 64'(exp_app));
      chk("pending", 64'(pending), 64'(mq.size()));
      chk("idle",    64'(idle),    64'(mq.size() == 0));
`ifdef DLY_SCHED_STATS_EN
      chk("stat_acc", 64'(stat_accepted),   64'(m_acc));
      chk("stat_sup", 64'(stat_superseded), 64'(m_sup));
`endif
   endtask

   task automatic idle_cycles(input int n);
      bit t;
      for (int i = 0; i < n; i++) step(1'b0, 8'd0, 32'd0, 1'b0, t);
   endtask

   // Hold a request until accepted, with a bounded wait.
   task automatic send(input logic [7:0] d, input logic [31:0] dat);
      bit t;
      t = 1'b0;
      for (int c = 0; c < 400 && !t; c++) step(1'b1, d, dat, 1'b0, t);
      if (!t) chk("send_timeout", 64'(t), 64'd1);
      bus.req_valid = 1'b0;
   endtask

   initial begin
      bit          t;
      int          e0;
      int          e5;
      int          napp;
      int          app_edge;
      bit          hold;
      bit          rv;
      bit          rr;
      logic [7:0]  rd;
      logic [31:0] rdat;

      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_delay = '0;
      bus.req_data  = '0;
      step(1'b0, 8'd0, 32'd0, 1'b1, t);
      step(1'b0, 8'd0, 32'd0, 1'b1, t);
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_pend", 64'(pending), 64'd0);
      chk("rst_q", 64'(dly_q), 64'(RVAL));

      // Delay 0: visible one cycle after accept.
      send(8'd0, 32'h11);
      idle_cycles(1);
      chk("d0_q", 64'(dly_q), 64'h11);
      chk("d0_app", 64'(applied), 64'd1);

      // Delay 5: unchanged for 5 cycles, new value on the 6th.
      send(8'd5, 32'h23);
      idle_cycles(5);
      chk("d5_hold", 64'(dly_q), 64'h11);
      chk("d5_pend", 64'(pending), 64'd1);
      idle_cycles(1);
      chk("d5_q", 64'(dly_q), 64'h23);
      chk("d5_pend0", 64'(pending), 64'd0);

      // Collision: both mature on the same edge, newer value wins, one pulse.
      send(8'd3, 32'hA);
      send(8'd2, 32'hB);
      napp = 0;
      for (int i = 0; i < 6; i++) begin
         idle_cycles(1);
         napp += int'(applied);
      end
      chk("col_q", 64'(dly_q), 64'hB);
      chk("col_pulses", 64'(napp), 64'd1);

      // Full: four long writes block the fifth until the first retires.
      send(8'd55, 32'h100);
      e0 = last_acc_edge;
      send(8'd55, 32'h101);
      send(8'd55, 32'h102);
      send(8'd55, 32'h103);
      chk("full_rdy", 64'(bus.req_ready), 64'd0);
      send(8'd55, 32'h104);
      e5 = last_acc_edge;
      chk("full_acc_edge", 64'(e5 - e0), 64'd57);
      idle_cycles(60);
      chk("full_last_q", 64'(dly_q), 64'h104);

      // Reset mid-flight discards everything.
      send(8'd20, 32'h201);
      send(8'd20, 32'h202);
      send(8'd20, 32'h203);
      chk("pre_rst_pend", 64'(pending), 64'd3);
      step(1'b0, 8'd0, 32'd0, 1'b1, t);
      chk("mid_rst_pend", 64'(pending), 64'd0);
      chk("mid_rst_q", 64'(dly_q), 64'(RVAL));
      napp = 0;
      for (int i = 0; i < 30; i++) begin
         idle_cycles(1);
         napp += int'(applied);
      end
      chk("rst_no_apply", 64'(napp), 64'd0);

      // Maximum delay: applied exactly 256 edges after accept.
      send(8'd255, 32'h55);
      e0       = last_acc_edge;
      app_edge = -1;
      for (int c = 0; c < 300 && app_edge < 0; c++) begin
         idle_cycles(1);
         if (applied === 1'b1) app_edge = edge_n;
      end
      chk("maxdly_lat", 64'(app_edge - e0), 64'd256);
      chk("maxdly_q", 64'(dly_q), 64'h55);

      // Random traffic with held requests and occasional reset.
      hold = 1'b0;
      rv = 1'b0; rd = '0; rdat = '0;
      for (int c = 0; c < 3000; c++) begin
         if (!hold) begin
            rv   = ($urandom_range(0, 1) == 1);
            rd   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 6));
            rdat = $urandom;
         end
         rr = ($urandom_range(0, 299) == 0);
         step(rv, rd, rdat, rr, t);
         hold = rv && !t;
      end
      bus.req_valid = 1'b0;
      idle_cycles(300);
      chk("drain_idle", 64'(idle), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
